// File: rtl/camellia_round_ctrl_if.sv
// Handshake/control bundle between a block requester and the Camellia-128
// round sequencer.
//   start      request a block operation
//   decrypt    mode for the requested operation (1 = decrypt)
//   key_ready  key schedule holds valid subkeys
//   abort      cancel the operation in progress
//   busy       operation in progress (PRE..POST)
//   done       one-cycle completion pulse
//   ld_in      load input block into the state register
//   kw_en      apply whitening; kw_sel picks kw1||kw2 (0) or kw3||kw4 (1)
//   rnd_en     F-round stage enable; rnd_idx is the round subkey index
//   fl_en      FL stage register enable; fl_ke_sel is the left-half ke index
interface camellia_round_ctrl_if;
    logic       start;
    logic       decrypt;
    logic       key_ready;
    logic       abort;
    logic       busy;
    logic       done;
    logic       ld_in;
    logic       kw_en;
    logic       kw_sel;
    logic       rnd_en;
    logic [4:0] rnd_idx;
    logic       fl_en;
    logic [1:0] fl_ke_sel;

    modport master (
        output start, decrypt, key_ready, abort,
        input  busy, done, ld_in, kw_en, kw_sel, rnd_en, rnd_idx, fl_en, fl_ke_sel
    );

    modport slave (
        input  start, decrypt, key_ready, abort,
        output busy, done, ld_in, kw_en, kw_sel, rnd_en, rnd_idx, fl_en, fl_ke_sel
    );
endinterface

// File: rtl/camellia_round_ctrl.sv
// Sequencing controller for an iterative Camellia-128 datapath.
// Walks the datapath through input whitening, 18 F-rounds with FL/FL^-1
// layers after rounds 6 and 12, and output whitening. Decryption runs the
// same sequence with the subkey order reversed.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  synchronous active-low reset
//   bus      slave side of camellia_round_ctrl_if (requests in, datapath
//            controls and status out)
// All outputs are decoded from registered state only.
module camellia_round_ctrl (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    camellia_round_ctrl_if.slave        bus
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StPre   = 3'd1,
        StRound = 3'd2,
        StFl    = 3'd3,
        StPost  = 3'd4,
        StDone  = 3'd5
    } state_e;

    state_e     r_state;
    state_e     w_state_d;
    logic [4:0] r_rnd_cnt;
    logic [4:0] w_rnd_cnt_d;
    logic       r_mode;
    logic       w_mode_d;

    logic       w_busy;
    logic       w_done;
    logic       w_ld_in;
    logic       w_kw_en;
    logic       w_kw_sel;
    logic       w_rnd_en;
    logic [4:0] w_rnd_idx;
    logic       w_fl_en;
    logic [1:0] w_fl_ke_sel;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_rnd_cnt <= 5'd0;
            r_mode    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_rnd_cnt <= w_rnd_cnt_d;
            r_mode    <= w_mode_d;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_d   = r_state;
        w_rnd_cnt_d = r_rnd_cnt;
        w_mode_d    = r_mode;
        unique case (r_state)
            StIdle: begin
                if (bus.start && bus.key_ready) begin
                    w_state_d   = StPre;
                    w_rnd_cnt_d = 5'd0;
                    w_mode_d    = bus.decrypt;
                end
            end
            StPre:   w_state_d = StRound;
            StRound: begin
                // Counter stops at 17 rather than wrapping.
                if (r_rnd_cnt == 5'd17) begin
                    w_state_d = StPost;
                end else begin
                    w_rnd_cnt_d = r_rnd_cnt + 5'd1;
                    if (r_rnd_cnt == 5'd5 || r_rnd_cnt == 5'd11) begin
                        w_state_d = StFl;
                    end
                end
            end
            StFl:    w_state_d = StRound;
            StPost:  w_state_d = StDone;
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
        // Abort overrides any transition while an operation is in flight.
        if (w_busy && bus.abort) begin
            w_state_d   = StIdle;
            w_rnd_cnt_d = 5'd0;
        end
    end

    // Moore output decode; inactive fields stay 0.
    always_comb begin
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_ld_in     = 1'b0;
        w_kw_en     = 1'b0;
        w_kw_sel    = 1'b0;
        w_rnd_en    = 1'b0;
        w_rnd_idx   = 5'd0;
        w_fl_en     = 1'b0;
        w_fl_ke_sel = 2'd0;
        unique case (r_state)
            StPre: begin
                w_busy   = 1'b1;
                w_ld_in  = 1'b1;
                w_kw_en  = 1'b1;
                w_kw_sel = r_mode;
            end
            StRound: begin
                w_busy    = 1'b1;
                w_rnd_en  = 1'b1;
                w_rnd_idx = r_mode ? (5'd17 - r_rnd_cnt) : r_rnd_cnt;
            end
            StFl: begin
                w_busy  = 1'b1;
                w_fl_en = 1'b1;
                // rnd_cnt is 6 in the first layer, 12 in the second.
                if (r_rnd_cnt == 5'd6) begin
                    w_fl_ke_sel = r_mode ? 2'd3 : 2'd0;
                end else begin
                    w_fl_ke_sel = r_mode ? 2'd1 : 2'd2;
                end
            end
            StPost: begin
                w_busy   = 1'b1;
                w_kw_en  = 1'b1;
                w_kw_sel = ~r_mode;
            end
            StDone:  w_done = 1'b1;
            default: ;
        endcase
    end

    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.ld_in     = w_ld_in;
    assign bus.kw_en     = w_kw_en;
    assign bus.kw_sel    = w_kw_sel;
    assign bus.rnd_en    = w_rnd_en;
    assign bus.rnd_idx   = w_rnd_idx;
    assign bus.fl_en     = w_fl_en;
    assign bus.fl_ke_sel = w_fl_ke_sel;

endmodule

// File: tb/tb_camellia_round_ctrl.sv
// Scoreboard bench for camellia_round_ctrl. The reference model tracks the
// position (1..23) within the block timeline after an accepted start and
// derives every output from that position.
module tb_camellia_round_ctrl;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       ld_in;
        logic       kw_en;
        logic       kw_sel;
        logic       rnd_en;
        logic [4:0] rnd_idx;
        logic       fl_en;
        logic [1:0] fl_ke_sel;
    } out_t;

    logic clk;
    logic rst_n;

    camellia_round_ctrl_if bus ();

    camellia_round_ctrl dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    out_t q_exp[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_pos   = 0;   // 0 = idle, 1..23 = cycle index after accept
    bit   m_mode  = 1'b0;
    int   m_dones = 0;
    int   o_dones = 0;

    // Expected outputs at a given timeline position.
    function automatic out_t expect_at(input int pos, input bit mode);
        out_t e;
        int   r;
        e = '0;
        if (pos == 1) begin
            e.busy = 1; e.ld_in = 1; e.kw_en = 1; e.kw_sel = mode;
        end else if (pos == 8) begin
            e.busy = 1; e.fl_en = 1; e.fl_ke_sel = mode ? 2'd3 : 2'd0;
        end else if (pos == 15) begin
            e.busy = 1; e.fl_en = 1; e.fl_ke_sel = mode ? 2'd1 : 2'd2;
        end else if (pos >= 2 && pos <= 21) begin
            r = pos - 2 - ((pos > 8) ? 1 : 0) - ((pos > 15) ? 1 : 0);
            e.busy = 1; e.rnd_en = 1;
            e.rnd_idx = 5'(mode ? 17 - r : r);
        end else if (pos == 22) begin
            e.busy = 1; e.kw_en = 1; e.kw_sel = ~mode;
        end else if (pos == 23) begin
            e.done = 1;
        end
        return e;
    endfunction

    // Apply inputs for one clock edge, advance the model, push expectation.
    task automatic drive(input bit rst, input bit st, input bit dec, input bit kr, input bit ab);
        out_t e;
        rst_n         = rst;
        bus.start     = st;
        bus.decrypt   = dec;
        bus.key_ready = kr;
        bus.abort     = ab;
        if (!rst) begin
            m_pos  = 0;
            m_mode = 0;
        end else if (m_pos == 0) begin
            if (st && kr) begin
                m_pos  = 1;
                m_mode = dec;
            end
        end else if (ab && m_pos <= 22) begin
            m_pos = 0;
        end else begin
            m_pos = (m_pos == 23) ? 0 : m_pos + 1;
        end
        e = expect_at(m_pos, m_mode);
        if (e.done) m_dones++;
        q_exp.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 1, 0);
    endtask

    // Monitor: one expectation per clock edge, sampled after the edge.
    initial begin
        out_t a;
        out_t e;
        forever begin
            @(posedge clk);
            #1;
            a = '{busy: bus.busy, done: bus.done, ld_in: bus.ld_in, kw_en: bus.kw_en,
                  kw_sel: bus.kw_sel, rnd_en: bus.rnd_en, rnd_idx: bus.rnd_idx,
                  fl_en: bus.fl_en, fl_ke_sel: bus.fl_ke_sel};
            if (a.done === 1'b1) o_dones++;
            n_tests++;
            if (q_exp.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow at %0t: got %h, required an expectation",
                         $time, a);
            end else begin
                e = q_exp.pop_front();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs at %0t: got busy=%b done=%b ld=%b kw=%b/%b rnd=%b/%0d fl=%b/%0d, required busy=%b done=%b ld=%b kw=%b/%b rnd=%b/%0d fl=%b/%0d",
                             $time, a.busy, a.done, a.ld_in, a.kw_en, a.kw_sel, a.rnd_en,
                             a.rnd_idx, a.fl_en, a.fl_ke_sel, e.busy, e.done, e.ld_in,
                             e.kw_en, e.kw_sel, e.rnd_en, e.rnd_idx, e.fl_en, e.fl_ke_sel);
                end
            end
        end
    end

    initial begin
        // Reset held 3 cycles with start asserted.
        for (int i = 0; i < 3; i++) drive(0, 1, 1, 1, 0);
        // Start without key_ready is ignored.
        for (int i = 0; i < 5; i++) drive(1, 1, 0, 0, 0);
        // Single encrypt, then single decrypt.
        drive(1, 1, 0, 1, 0);
        idle(30);
        drive(1, 1, 1, 1, 0);
        idle(30);
        // Start held high: one accept per 24 cycles, mode toggling during busy.
        for (int i = 0; i < 60; i++) drive(1, 1, i[0], 1, 0);
        idle(5);
        // Abort at T+10, restart at T+11.
        drive(1, 1, 0, 1, 0);
        idle(9);
        drive(1, 0, 0, 1, 1);
        drive(1, 1, 1, 1, 0);
        idle(30);
        // Reset during the second FL layer.
        drive(1, 1, 0, 1, 0);
        idle(14);
        drive(0, 0, 0, 1, 0);
        idle(30);
        // Abort in DONE and IDLE has no effect.
        drive(1, 1, 0, 1, 0);
        idle(22);
        drive(1, 1, 0, 1, 1);
        drive(1, 0, 0, 1, 1);
        idle(3);
        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 299) != 0),
                  ($urandom_range(0, 3) == 0),
                  1'($urandom),
                  ($urandom_range(0, 4) != 0),
                  ($urandom_range(0, 49) == 0));
        end
        idle(30);

        n_tests++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", q_exp.size());
        end
        n_tests++;
        if (o_dones != m_dones) begin
            n_fail++;
            $display("FAIL done_count: got %0d, required %0d", o_dones, m_dones);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/camellia_round_ctrl.md
# camellia_round_ctrl

Sequencing controller for the Camellia-128 iterative datapath: one F-round stage and the registered FL/FL⁻¹ stage. It accepts a start request and walks the datapath through input whitening, 18 F-rounds, two FL layers and output whitening. It drives the subkey indices and enables the round, FL and whitening logic. It supports encryption and decryption; decryption uses reversed subkey order.

## Interface
- Parameters: none (fixed Camellia-128 schedule: 18 rounds, FL layers after rounds 6 and 12).
- clk  in  1  system clock, rising edge.
- RST  in  1  reset: synchronous, active-low; sampled on rising clk.
- start  in  1  request a block operation; accepted only in IDLE with key_ready=1.
- decrypt  in  1  mode, sampled and latched with an accepted start (0=encrypt, 1=decrypt).
- key_ready  in  1  key schedule holds valid kw/k/ke subkeys.
- abort  in  1  synchronous cancel of an operation in progress.
- busy  out  1  high from PRE through POST inclusive.
- done  out  1  one-cycle pulse; the datapath output register holds the result.
- ld_in  out  1  load the plaintext/ciphertext into the state register (PRE only).
- kw_en  out  1  apply whitening (PRE and POST).
- kw_sel  out  1  0 = kw1‖kw2, 1 = kw3‖kw4.
- rnd_en  out  1  F-round stage enable.
- rnd_idx  out  5  round subkey index 0..17 (k1..k18).
- fl_en  out  1  capture FL/FL⁻¹ result (FL stage register enable).
- fl_ke_sel  out  2  ke index for FL on the left half (0=ke1..3=ke4); FL⁻¹ on the right half uses fl_ke_sel^1.

## Operation
- States: IDLE, PRE, ROUND, FL, POST, DONE. State is held in a register with a 5-bit round counter rnd_cnt (0..17) and a latched mode bit.
- IDLE: if start & key_ready, latch decrypt, clear rnd_cnt, go to PRE. Otherwise stay. start with key_ready=0 is ignored and is not queued.
- PRE (1 cycle): ld_in=1, kw_en=1, kw_sel = mode. Next state is ROUND.
- ROUND (1 cycle per round): rnd_en=1, rnd_idx = rnd_cnt in encrypt mode or 17−rnd_cnt in decrypt mode. rnd_cnt increments. Exit conditions:
  - after rnd_cnt=5 or 11: go to FL;
  - after rnd_cnt=17: go to POST;
  - otherwise stay in ROUND.
- FL (1 cycle): fl_en=1. fl_ke_sel values:
  - encrypt: 0 in the first layer, 2 in the second;
  - decrypt: 3 in the first layer, 1 in the second.
  - Layer is identified by rnd_cnt (6 = first, 12 = second). Next state is ROUND.
- POST (1 cycle): kw_en=1, kw_sel = ~mode. Next state is DONE.
- DONE (1 cycle): done=1, busy=0. Next state is IDLE. start in DONE is ignored.
- abort=1 in PRE/ROUND/FL/POST: next state is IDLE, no done, rnd_cnt cleared. abort in IDLE or DONE has no effect. abort has priority over the normal transition.
- The start/key_ready values during busy are don't-care and are never queued. Mode changes during busy are ignored.
- All outputs are decoded from registered state only (Moore); there is no input-to-output combinational path.
- Inactive outputs are 0: rnd_idx=0 outside ROUND, fl_ke_sel=0 outside FL, kw_sel=0 outside PRE/POST.

## Timing
- Reset (RST=0 at a clk edge): state IDLE, rnd_cnt=0, mode=0. All outputs are 0 the following cycle. Reset mid-operation discards the operation and produces no done.
- Start accepted at edge T: PRE in cycle T+1, ROUNDs 0–5 in T+2..T+7, FL1 in T+8, ROUNDs 6–11 in T+9..T+14, FL2 in T+15, ROUNDs 12–17 in T+16..T+21, POST in T+22, DONE in T+23.
- busy is high for 22 cycles. Latency from start to done is 23 cycles. The earliest next start is accepted in the IDLE cycle T+24, giving a throughput of one block per 24 cycles.
- The datapath FL stage registers on the fl_en cycle, so its result is valid the next cycle (the first round after the FL layer).
- rnd_cnt never exceeds 17 and never wraps.

## Test plan
- Reset: hold RST=0 for 3 cycles with start=1 -> all outputs 0 and state IDLE. After release with key_ready=0, start is ignored and busy stays 0.
- Encrypt (decrypt=0, start pulse at T) -> ld_in and kw_sel=0 at T+1; rnd_idx 0..5 in T+2..T+7; fl_en with fl_ke_sel=0 at T+8; fl_ke_sel=2 at T+15; rnd_idx=17 at T+21; kw_sel=1 at T+22; done at T+23. Datapath result matches the RFC 3713 test vector 0x67673138549669730857065648eabe43.
- Decrypt, same key -> rnd_idx 17..0; fl_ke_sel 3 at T+8 and 1 at T+15; kw_sel 1 then 0. Datapath returns plaintext 0x0123456789abcdeffedcba9876543210.
- Start held high continuously -> one operation per 24 cycles. Second accept at T+24; no start is accepted during busy or DONE.
- Abort at T+10 -> IDLE at T+11, busy=0, no done. A new start at T+11 produces done at T+34.
- RST=0 at T+15 (FL2 cycle) -> all outputs 0 at T+16, no done pulse afterward.
